score_counter: RTL and testbench

Sequential score keeper that sits directly upstream of the on-screen score renderer and drives its 10-bit `Total_Score` input. It accumulates zombie kills reported by the game logic into a pending register and commits them to the displayed score once per video frame, so the two digits never change mid-scan. It runs a small game-phase FSM and, optionally, a persistent high-score register.

---
 rtl/score_counter.sv | 131 +++++++++++++
 tb/tb_score_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// Frame-synchronous score keeper: accumulates kills into a pending register and commits them on each frame tick.
// Optional persistent high-score register is built when SCORE_HIGHSCORE_EN is defined.
module score_counter #(
  parameter int MAX_SCORE       = 99,
  parameter int POINTS_PER_KILL = 1,
  parameter int KILL_W          = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Game_Start,
  input  logic              Player_Dead,
  input  logic [KILL_W-1:0] Kill_Count,
  input  logic              Frame_Clk,
  output logic [9:0]        Total_Score,
  output logic [9:0]        High_Score,
  output logic              Score_Changed,
  output logic [1:0]        Game_State
);

  // state        | meaning
  // ST_IDLE      | after reset, kills ignored, waiting for Game_Start
  // ST_PLAYING   | kills accumulate into pending, committed on frame ticks
  // ST_GAME_OVER | kills ignored, first tick flushes pending, then score frozen
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_PLAYING   = 2'b01,
    ST_GAME_OVER = 2'b10
  } state_t;

  localparam logic [10:0] MAX_11 = 11'(MAX_SCORE);

  state_t      state, state_nxt;
  logic        frame_q;
  logic        frame_tick;
  logic [9:0]  pending;
  logic        clear;
  logic        commit;
  logic [10:0] kill_pts;
  logic [10:0] pend_sum;
  logic [10:0] total_sum;
  logic [9:0]  pend_new;
  logic [9:0]  total_new;

  function automatic logic [9:0] sat(input logic [10:0] x);
    if (x > MAX_11) return MAX_11[9:0];
    else            return x[9:0];
  endfunction

  assign frame_tick = Frame_Clk & ~frame_q;
  assign kill_pts   = (state == ST_PLAYING) ? 11'(Kill_Count) * 11'(POINTS_PER_KILL) : 11'd0;
  assign pend_sum   = {1'b0, pending} + kill_pts;
  assign total_sum  = {1'b0, Total_Score} + {1'b0, pending} + kill_pts;
  assign pend_new   = sat(pend_sum);
  assign total_new  = sat(total_sum);
  assign Game_State = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Game_Start outranks both Player_Dead and a coincident frame tick.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Game_Start) begin
          state_nxt = ST_PLAYING;
          clear     = 1'b1;
        end else begin
          commit = frame_tick;
        end
      end
      ST_PLAYING: begin
        if (Game_Start) begin
          clear = 1'b1;
        end else begin
          commit = frame_tick;
          if (Player_Dead) state_nxt = ST_GAME_OVER;
        end
      end
      ST_GAME_OVER: begin
        if (Game_Start) begin
          state_nxt = ST_PLAYING;
          clear     = 1'b1;
        end else begin
          commit = frame_tick;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_q       <= 1'b0;
      pending       <= '0;
      Total_Score   <= '0;
      Score_Changed <= 1'b0;
    end else begin
      frame_q       <= Frame_Clk;
      Score_Changed <= 1'b0;
      if (clear) begin
        Total_Score <= '0;
        pending     <= '0;
      end else if (commit) begin
        Total_Score   <= total_new;
        pending       <= '0;
        Score_Changed <= (total_new != Total_Score);
      end else if (state == ST_PLAYING) begin
        pending <= pend_new;
      end
    end
  end

`ifdef SCORE_HIGHSCORE_EN
  // Only sample once pending is flushed, so the best score is the final committed one.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      High_Score <= '0;
    end else if (state == ST_GAME_OVER && pending == '0 && Total_Score > High_Score) begin
      High_Score <= Total_Score;
    end
  end
`else
  assign High_Score = '0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Directed, table-driven bench for score_counter; high-score expectations follow SCORE_HIGHSCORE_EN.
module tb_score_counter;

`ifdef SCORE_HIGHSCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic       Game_Start;
  logic       Player_Dead;
  logic [2:0] Kill_Count;
  logic       Frame_Clk;
  logic [9:0] Total_Score;
  logic [9:0] High_Score;
  logic       Score_Changed;
  logic [1:0] Game_State;

  int checks   = 0;
  int failures = 0;

  score_counter dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Game_Start    (Game_Start),
    .Player_Dead   (Player_Dead),
    .Kill_Count    (Kill_Count),
    .Frame_Clk     (Frame_Clk),
    .Total_Score   (Total_Score),
    .High_Score    (High_Score),
    .Score_Changed (Score_Changed),
    .Game_State    (Game_State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       gs;
    logic       pd;
    logic [2:0] k;
    logic       f;
    logic [9:0] et;
    logic       ec;
    logic [1:0] es;
    logic [9:0] eh;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic gs, input logic pd, input logic [2:0] k, input logic f,
                              input int et, input logic ec, input logic [1:0] es, input int eh);
    vec_t v;
    v.gs = gs; v.pd = pd; v.k = k; v.f = f;
    v.et = 10'(et); v.ec = ec; v.es = es;
    v.eh = HS_EN ? 10'(eh) : 10'd0;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic gs, input logic pd, input logic [2:0] k, input logic f);
    @(negedge Clk);
    Game_Start  = gs;
    Player_Dead = pd;
    Kill_Count  = k;
    Frame_Clk   = f;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0; Game_Start = 1'b0; Player_Dead = 1'b0; Kill_Count = '0; Frame_Clk = 1'b0;

    // IDLE kill+tick, first game to 5, saturation at 99
    add(0,0,3,1,  0,0,0,0);
    add(1,0,0,0,  0,0,1,0);
    for (int i = 0; i < 5; i++) add(0,0,1,0, 0,0,1,0);
    add(0,0,0,1,  5,1,1,0);
    add(0,0,0,1,  5,0,1,0);
    add(0,0,0,0,  5,0,1,0);
    for (int i = 0; i < 13; i++) add(0,0,7,0, 5,0,1,0);
    add(0,0,1,0,  5,0,1,0);
    add(0,0,0,1, 97,1,1,0);
    add(0,0,0,0, 97,0,1,0);
    add(0,0,7,1, 99,1,1,0);
    add(0,0,0,0, 99,0,1,0);
    add(0,0,7,1, 99,0,1,0);
    add(0,0,0,0, 99,0,1,0);
    // restart with coincident tick: clear wins, kills on that cycle dropped
    add(1,0,5,1,  0,0,1,0);
    add(0,0,0,0,  0,0,1,0);
    add(0,0,0,1,  0,0,1,0);
    add(0,0,0,0,  0,0,1,0);
    // score 10, pending 3, die, flush on GAME_OVER tick
    add(0,0,7,0,  0,0,1,0);
    add(0,0,3,0,  0,0,1,0);
    add(0,0,0,1, 10,1,1,0);
    add(0,0,3,0, 10,0,1,0);
    add(0,1,0,0, 10,0,2,0);
    add(0,0,4,0, 10,0,2,0);
    add(0,0,2,1, 13,1,2,0);
    add(0,0,0,0, 13,0,2,13);
    add(0,0,5,1, 13,0,2,13);
    add(0,1,0,0, 13,0,2,13);
    // second game: start+dead together, then dead+tick ending at 8
    add(1,0,0,0,  0,0,1,13);
    add(1,1,0,0,  0,0,1,13);
    add(0,0,7,0,  0,0,1,13);
    add(0,0,1,0,  0,0,1,13);
    add(0,1,0,1,  8,1,2,13);
    add(0,0,0,0,  8,0,2,13);
    add(0,0,0,0,  8,0,2,13);

    #3;
    chk("reset_total",   Total_Score,   0);
    chk("reset_high",    High_Score,    0);
    chk("reset_changed", Score_Changed, 0);
    chk("reset_state",   Game_State,    0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].gs, vecs[i].pd, vecs[i].k, vecs[i].f);
      chk($sformatf("vec%0d_total", i),   Total_Score,   vecs[i].et);
      chk($sformatf("vec%0d_changed", i), Score_Changed, vecs[i].ec);
      chk($sformatf("vec%0d_state", i),   Game_State,    vecs[i].es);
      chk($sformatf("vec%0d_high", i),    High_Score,    vecs[i].eh);
    end

    // third game to 42, then async reset between clock edges
    step(1,0,0,0);
    for (int i = 0; i < 6; i++) step(0,0,7,0);
    step(0,0,0,1);
    chk("pre_reset_total",   Total_Score,   42);
    chk("pre_reset_changed", Score_Changed, 1);
    chk("pre_reset_state",   Game_State,    1);
    Reset = 1'b0;
    #1;
    chk("async_total",   Total_Score,   0);
    chk("async_changed", Score_Changed, 0);
    chk("async_state",   Game_State,    0);
    chk("async_high",    High_Score,    0);
    @(negedge Clk);
    Reset = 1'b1;
    step(0,0,0,0);
    step(0,0,3,1);
    chk("idle_tick_total", Total_Score, 0);
    chk("idle_tick_state", Game_State,  0);
    step(0,0,3,0);
    chk("idle_final_total", Total_Score, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
